wb_frame_reader: RTL and testbench

// Wishbone master (initiator) that streams a frame buffer out of Wishbone memory

---
 rtl/wb_frame_reader_pkg.sv | 20 ++
 rtl/wb_frame_reader_if.sv | 46 ++++
 rtl/wb_frame_reader_fifo.sv | 67 ++++++
 rtl/wb_frame_reader.sv | 121 ++++++++++++
 tb/tb_wb_frame_reader.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_frame_reader_pkg.sv
// Shared constants and types for the Wishbone frame reader.
// Burst-type encodings, FSM state type and the FIFO word layout.
package wb_frame_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } rd_state_t;

    typedef struct packed {
        logic        sof;
        logic [31:0] data;
    } pix_word_t;

endpackage

// File: rtl/wb_frame_reader_if.sv
// Wishbone bus bundle with clock and reset carried alongside.
// Master drives the cycle; slave returns read data and ack.
interface wshb_if (
    input logic clk,
    input logic rst
);

    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_sm;
    logic        ack;

    modport master (
        input  clk,
        input  rst,
        input  dat_sm,
        input  ack,
        output cyc,
        output stb,
        output we,
        output sel,
        output adr,
        output cti,
        output bte
    );

    modport slave (
        input  clk,
        input  rst,
        input  cyc,
        input  stb,
        input  we,
        input  sel,
        input  adr,
        input  cti,
        input  bte,
        output dat_sm,
        output ack
    );

endinterface

// File: rtl/wb_frame_reader_fifo.sv
// Show-ahead synchronous FIFO with occupancy output.
// Head word is readable combinationally whenever valid is high.
module wb_sync_fifo #(
    parameter int AW = 8,
    parameter int W  = 33
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          valid,
    output logic [AW:0]   level
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          do_push;
    logic          do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign valid   = !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case (1'b1)
                (do_push && !do_pop): level <= level + (AW+1)'(1);
                (do_pop && !do_push): level <= level - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    // Space is reserved before each burst, so overflow means a logic bug.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && full));
        end
    end

endmodule

// File: rtl/wb_frame_reader.sv
// Wishbone burst-read master streaming a frame buffer into a pixel FIFO.
// Wraps to BASE_ADR at each frame end; bursts start only when space exists.
module wb_frame_reader
    import wb_frame_pkg::*;
#(
    parameter int          HDISP     = 800,
    parameter int          VDISP     = 480,
    parameter int          BURST_LEN = 16,
    parameter int          FIFO_AW   = 8,
    parameter logic [31:0] BASE_ADR  = 32'h0
) (
    wshb_if.master        wb_m,
    input  logic          enable,
    output logic [31:0]   pix_data,
    output logic          pix_sof,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [FIFO_AW:0] fifo_level,
    output logic          underrun
);

    localparam int FRAME = HDISP * VDISP;
    localparam int PW    = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam int BW    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int LW    = FIFO_AW + 1;
    localparam int DEPTH = 1 << FIFO_AW;

    logic            clk;
    logic            rst;
    rd_state_t       state;
    logic [PW-1:0]   pixel_cnt;
    logic [BW-1:0]   beat_cnt;
    logic            beat;
    logic            last_beat;
    logic            last_pix;
    logic            room;
    pix_word_t       wr_word;
    pix_word_t       rd_word;

    assign clk = wb_m.clk;
    assign rst = wb_m.rst;

    assign beat      = (state == BURST) && wb_m.ack;
    assign last_beat = (beat_cnt == BW'(BURST_LEN - 1));
    assign last_pix  = (pixel_cnt == PW'(FRAME - 1));
    assign room      = (LW'(DEPTH) - fifo_level) >= LW'(BURST_LEN);

    assign wb_m.cyc = (state == BURST);
    assign wb_m.stb = (state == BURST);
    assign wb_m.we  = 1'b0;
    assign wb_m.sel = 4'hF;
    assign wb_m.bte = BTE_LINEAR;
    assign wb_m.adr = BASE_ADR + 32'({pixel_cnt, 2'b00});

    // Single-beat configurations stay in classic cycles throughout.
    always_comb begin
        wb_m.cti = CTI_CLASSIC;
        if (state == BURST && BURST_LEN > 1) begin
            wb_m.cti = last_beat ? CTI_EOB : CTI_INCR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pixel_cnt <= '0;
            beat_cnt  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (enable && room) begin
                        state    <= BURST;
                        beat_cnt <= '0;
                    end
                end
                BURST: begin
                    if (wb_m.ack) begin
                        pixel_cnt <= last_pix ? '0 : pixel_cnt + PW'(1);
                        beat_cnt  <= beat_cnt + BW'(1);
                        if (last_beat) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            underrun <= 1'b0;
        end else if (pix_ready && !pix_valid) begin
            underrun <= 1'b1;
        end
    end

    always_comb begin
        wr_word      = '0;
        wr_word.sof  = (pixel_cnt == '0);
        wr_word.data = wb_m.dat_sm;
    end

    wb_sync_fifo #(
        .AW (FIFO_AW),
        .W  ($bits(pix_word_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (beat),
        .din   (wr_word),
        .pop   (pix_ready),
        .dout  (rd_word),
        .valid (pix_valid),
        .level (fifo_level)
    );

    assign pix_data = rd_word.data;
    assign pix_sof  = rd_word.sof;

endmodule

// File: tb/tb_wb_frame_reader.sv
// Bench for wb_frame_reader: BRAM slave model with wait states and
// a scoreboard of expected pixel words checked as they are consumed.
module tb_wb_frame_reader;
    import wb_frame_pkg::*;

    localparam int HD = 8;
    localparam int VD = 4;
    localparam int BL = 4;
    localparam int AW = 4;
    localparam int FR = HD * VD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wshb_if wb (.clk(clk), .rst(rst));

    logic          enable = 1'b0;
    logic          pix_ready = 1'b0;
    logic [31:0]   pix_data;
    logic          pix_sof;
    logic          pix_valid;
    logic [AW:0]   fifo_level;
    logic          underrun;

    wb_frame_reader #(
        .HDISP     (HD),
        .VDISP     (VD),
        .BURST_LEN (BL),
        .FIFO_AW   (AW),
        .BASE_ADR  (32'h0)
    ) dut (
        .wb_m       (wb),
        .enable     (enable),
        .pix_data   (pix_data),
        .pix_sof    (pix_sof),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .fifo_level (fifo_level),
        .underrun   (underrun)
    );

    int errors = 0;
    int checks = 0;

    // Slave memory holds mem[i] = i; wait_mode < 0 picks 0..2 waits at random.
    logic [31:0] mem [FR];
    int wait_cnt = 0;
    int wait_tgt = 0;
    int wait_mode = 0;
    bit ack_block = 1'b0;

    initial begin
        for (int i = 0; i < FR; i++) mem[i] = 32'(i);
    end

    function automatic int pick_wait();
        return (wait_mode < 0) ? int'($urandom_range(0, 2)) : wait_mode;
    endfunction

    assign wb.ack = wb.cyc && wb.stb && !ack_block && (wait_cnt >= wait_tgt);
    assign wb.dat_sm = mem[wb.adr[6:2]];

    always @(posedge clk) begin
        if (rst || !(wb.cyc && wb.stb) || wb.ack) begin
            wait_cnt <= 0;
            wait_tgt <= pick_wait();
        end else begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    // Scoreboard monitor
    pix_word_t exp_q [$];
    int exp_pix = 0;
    int beat_in_burst = 0;
    int bursts_done = 0;
    int pops = 0;
    int acks = 0;
    bit prev_hold = 1'b0;
    bit prev_last = 1'b0;

    always @(negedge clk) begin
        pix_word_t w;
        if (rst) begin
            exp_q.delete();
            exp_pix = 0;
            beat_in_burst = 0;
            prev_hold = 1'b0;
            prev_last = 1'b0;
        end else begin
            if (prev_last) begin
                checks++;
                if (wb.cyc !== 1'b0 || wb.stb !== 1'b0) begin
                    errors++;
                    $display("FAIL eob_release: cyc=%b stb=%b required 0 0", wb.cyc, wb.stb);
                end
            end else if (prev_hold) begin
                checks++;
                if (wb.cyc !== 1'b1 || wb.stb !== 1'b1) begin
                    errors++;
                    $display("FAIL stb_held: cyc=%b stb=%b required 1 1", wb.cyc, wb.stb);
                end
            end
            if (pix_valid && pix_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_extra: data=%0h with nothing expected", pix_data);
                end else begin
                    w = exp_q.pop_front();
                    if (pix_sof !== w.sof || pix_data !== w.data) begin
                        errors++;
                        $display("FAIL pix_word: got sof=%b data=%0h required sof=%b data=%0h",
                                 pix_sof, pix_data, w.sof, w.data);
                    end
                end
                pops++;
            end
            prev_last = 1'b0;
            prev_hold = wb.cyc && wb.stb;
            if (wb.cyc && wb.stb && wb.ack) begin
                checks++;
                if (wb.adr !== 32'(exp_pix * 4)) begin
                    errors++;
                    $display("FAIL beat_adr: got %0h required %0h", wb.adr, exp_pix * 4);
                end
                checks++;
                if (wb.cti !== ((beat_in_burst == BL - 1) ? CTI_EOB : CTI_INCR)) begin
                    errors++;
                    $display("FAIL beat_cti: got %b at beat %0d", wb.cti, beat_in_burst);
                end
                checks++;
                if (wb.we !== 1'b0 || wb.sel !== 4'hF || wb.bte !== 2'b00) begin
                    errors++;
                    $display("FAIL beat_ctl: we=%b sel=%h bte=%b required 0 f 00",
                             wb.we, wb.sel, wb.bte);
                end
                w.sof = (exp_pix == 0);
                w.data = 32'(exp_pix);
                exp_q.push_back(w);
                exp_pix = (exp_pix + 1) % FR;
                acks++;
                beat_in_burst++;
                if (beat_in_burst == BL) begin
                    beat_in_burst = 0;
                    bursts_done++;
                    prev_last = 1'b1;
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (wb.cyc !== 1'b0 || wb.stb !== 1'b0) begin
            errors++;
            $display("FAIL reset_cyc: cyc=%b stb=%b required 0 0", wb.cyc, wb.stb);
        end
        checks++;
        if (wb.we !== 1'b0 || wb.sel !== 4'hF || wb.cti !== 3'b000 || wb.bte !== 2'b00) begin
            errors++;
            $display("FAIL reset_ctl: we=%b sel=%h cti=%b bte=%b", wb.we, wb.sel, wb.cti, wb.bte);
        end
        checks++;
        if (wb.adr !== 32'h0) begin
            errors++;
            $display("FAIL reset_adr: got %0h required 0", wb.adr);
        end
        checks++;
        if (pix_valid !== 1'b0 || fifo_level !== '0) begin
            errors++;
            $display("FAIL reset_fifo: valid=%b level=%0d required 0 0", pix_valid, fifo_level);
        end
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_underrun: got %b required 0", underrun);
        end
        rst = 1'b0;
    endtask

    task automatic test_fill();
        int b0;
        int n;
        b0 = bursts_done;
        wait_mode = -1;
        pix_ready = 1'b0;
        enable = 1'b1;
        n = 0;
        while (fifo_level != 5'd16 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (wb.cyc !== 1'b0 || fifo_level !== 5'd16) begin
            errors++;
            $display("FAIL fill_stall: cyc=%b level=%0d required 0 16", wb.cyc, fifo_level);
        end
        checks++;
        if (bursts_done - b0 != 4) begin
            errors++;
            $display("FAIL fill_bursts: got %0d required 4", bursts_done - b0);
        end
        checks++;
        if (pix_data !== 32'h0 || pix_sof !== 1'b1 || pix_valid !== 1'b1) begin
            errors++;
            $display("FAIL fill_head: data=%0h sof=%b valid=%b required 0 1 1",
                     pix_data, pix_sof, pix_valid);
        end
    endtask

    task automatic test_stream();
        int p0;
        int n;
        wait_mode = 0;
        p0 = pops;
        pix_ready = 1'b1;
        n = 0;
        while (pops - p0 < 40 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        pix_ready = 1'b0;
        checks++;
        if (pops - p0 < 40) begin
            errors++;
            $display("FAIL stream_count: got %0d pops required 40", pops - p0);
        end
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("FAIL stream_underrun: got %b required 0", underrun);
        end
    endtask

    task automatic test_wait_states();
        int a0;
        int n;
        wait_mode = 3;
        pix_ready = 1'b1;
        a0 = acks;
        n = 0;
        while (acks - a0 < 12 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (acks - a0 < 12) begin
            errors++;
            $display("FAIL wait_acks: got %0d required 12", acks - a0);
        end
        checks++;
        if (n < 44) begin
            errors++;
            $display("FAIL wait_span: 12 acks took %0d cycles required >= 44", n);
        end
    endtask

    task automatic test_enable_drop();
        int b0;
        int p0;
        int n;
        wait_mode = -1;
        pix_ready = 1'b1;
        enable = 1'b1;
        n = 0;
        while (beat_in_burst != 2 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        enable = 1'b0;
        b0 = bursts_done;
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if (wb.cyc !== 1'b0 || bursts_done != b0 + 1 || beat_in_burst != 0) begin
            errors++;
            $display("FAIL enable_drop: cyc=%b bursts=%0d beat=%0d required 0 %0d 0",
                     wb.cyc, bursts_done - b0, beat_in_burst, 1);
        end
        p0 = exp_pix;
        enable = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(wb.cyc && wb.stb && wb.ack) && n < 100);
        checks++;
        if (wb.adr !== 32'(p0 * 4) || !wb.ack) begin
            errors++;
            $display("FAIL enable_resume: adr=%0h ack=%b required %0h 1", wb.adr, wb.ack, p0 * 4);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        wait_mode = -1;
        pix_ready = 1'b1;
        enable = 1'b1;
        n = 0;
        while (beat_in_burst != 1 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (wb.cyc !== 1'b0 || wb.stb !== 1'b0 || fifo_level !== '0) begin
            errors++;
            $display("FAIL midrst_clear: cyc=%b stb=%b level=%0d required 0 0 0",
                     wb.cyc, wb.stb, fifo_level);
        end
        n = 0;
        while (!(wb.cyc && wb.stb && wb.ack) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (wb.adr !== 32'h0 || !wb.ack) begin
            errors++;
            $display("FAIL midrst_adr: adr=%0h ack=%b required 0 1", wb.adr, wb.ack);
        end
        n = 0;
        while (!pix_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (pix_valid !== 1'b1 || pix_sof !== 1'b1 || pix_data !== 32'h0) begin
            errors++;
            $display("FAIL midrst_sof: valid=%b sof=%b data=%0h required 1 1 0",
                     pix_valid, pix_sof, pix_data);
        end
    endtask

    task automatic test_underrun();
        ack_block = 1'b1;
        pix_ready = 1'b1;
        enable = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("FAIL underrun_rst: got %b required 0", underrun);
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (underrun !== 1'b1) begin
            errors++;
            $display("FAIL underrun_set: got %b required 1", underrun);
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (underrun !== 1'b1 || wb.cyc !== 1'b1 || fifo_level !== '0) begin
            errors++;
            $display("FAIL underrun_sticky: underrun=%b cyc=%b level=%0d required 1 1 0",
                     underrun, wb.cyc, fifo_level);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("FAIL underrun_clear: got %b required 0", underrun);
        end
        ack_block = 1'b0;
        pix_ready = 1'b0;
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_stream();
        test_wait_states();
        test_enable_drop();
        test_reset_mid();
        test_underrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
